// File: rtl/motor_pkg.sv
// Shared types and constants for the motor sequencer.
package motor_pkg;

    localparam int LEVEL_W = 3;
    localparam int DUR_W   = 16;

    localparam logic [LEVEL_W-1:0] MAX_LEVEL = 3'd7;

    // Sequencer phases; only IDLE is "not busy".
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEAD      = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_RUN       = 3'd3,
        ST_RAMP_DOWN = 3'd4
    } motor_state_t;

endpackage

// File: rtl/tick_gen.sv
// Timing tick prescaler: one-cycle tick every TICK_DIV clocks, restartable
// so that each sequencer phase begins on a fresh tick boundary.
module tick_gen #(
    parameter int TICK_DIV = 50_000
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Count 0..TICK_DIV-1, wrap after the tick, restart on clear.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_seq_ctrl.sv
// Motion sequencer in front of the PWM generator: accepts one move at a
// time, inserts a coast period before reversing, ramps up, runs, ramps down.
// estop aborts any move on the next edge.
module motor_seq_ctrl
    import motor_pkg::*;
#(
    parameter int TICK_DIV   = 50_000,
    parameter int RAMP_TICKS = 100,
    parameter int DEAD_TICKS = 200
) (
    input  logic               sclk,
    input  logic               s_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [LEVEL_W-1:0] cmd_level,
    input  logic [DUR_W-1:0]   cmd_dur,
    input  logic               estop,
    output logic               pwm_en,
    output logic               pwm_dir,
    output logic [LEVEL_W-1:0] pwm_level,
    output logic               busy,
    output logic               done
);

    localparam logic [DUR_W-1:0] RAMP_CMP = DUR_W'(RAMP_TICKS);
    localparam logic [DUR_W-1:0] DEAD_CMP = DUR_W'(DEAD_TICKS);

    motor_state_t state_q, state_d;

    logic [LEVEL_W-1:0] tgt_level_q, tgt_level_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [DUR_W-1:0]   phase_q, phase_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               en_q, en_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tick;
    logic               accept;
    logic               transition;
    logic               level_step;
    logic               phase_last;
    logic [DUR_W-1:0]   phase_cmp;
    logic [DUR_W:0]     phase_inc;
    logic [LEVEL_W-1:0] level_up;
    logic [LEVEL_W-1:0] level_dn;

    // Every phase restarts the prescaler so its length is a whole number of ticks.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .clr     (transition),
        .tick    (tick)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !estop;
    assign accept    = cmd_valid && cmd_ready;

    assign transition = (state_d != state_q);
    assign level_up   = level_q + LEVEL_W'(1);
    assign level_dn   = (level_q == '0) ? '0 : level_q - LEVEL_W'(1);

    // The phase counter is compared against whichever length the current phase uses.
    always_comb begin
        phase_cmp = RAMP_CMP;
        case (state_q)
            ST_DEAD: phase_cmp = DEAD_CMP;
            ST_RUN:  phase_cmp = dur_q;
            default: phase_cmp = RAMP_CMP;
        endcase
    end

    // phase_last marks the tick that completes the current phase or level.
    assign phase_inc  = {1'b0, phase_q} + (DUR_W + 1)'(1);
    assign phase_last = tick && (phase_inc == {1'b0, phase_cmp});

    // Next-state and registered-output logic; estop overrides everything.
    always_comb begin
        state_d     = state_q;
        tgt_level_d = tgt_level_q;
        dur_d       = dur_q;
        level_d     = level_q;
        en_d        = en_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        level_step  = 1'b0;

        if (estop) begin
            state_d = ST_IDLE;
            level_d = '0;
            en_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tgt_level_d = cmd_level;
                        dur_d       = cmd_dur;
                        level_d     = '0;
                        if (cmd_dir != dir_q) begin
                            // Reverse only while coasting.
                            state_d = ST_DEAD;
                            dir_d   = cmd_dir;
                            en_d    = 1'b0;
                        end else begin
                            state_d = ST_RAMP_UP;
                            en_d    = 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (phase_last) begin
                        state_d = ST_RAMP_UP;
                        en_d    = 1'b1;
                    end
                end
                ST_RAMP_UP: begin
                    if (level_q == tgt_level_q) begin
                        // Only reachable on entry with a zero target.
                        state_d = ST_RUN;
                    end else if (phase_last && (level_q != MAX_LEVEL)) begin
                        level_step = 1'b1;
                        level_d    = level_up;
                        if (level_up == tgt_level_q) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if ((dur_q == '0) || phase_last) begin
                        // First ramp-down level starts as RUN ends.
                        state_d = ST_RAMP_DOWN;
                        level_d = level_dn;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (phase_last) begin
                        if (level_q == '0) begin
                            state_d = ST_IDLE;
                            en_d    = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            level_step = 1'b1;
                            level_d    = level_dn;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                    en_d    = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Phase counter: counts ticks, clears per phase/level, saturates at its compare value.
    always_comb begin
        phase_d = phase_q;
        if (transition || level_step) begin
            phase_d = '0;
        end else if (tick && (phase_q != phase_cmp)) begin
            phase_d = phase_q + DUR_W'(1);
        end
    end

    // State, latched command, counters and registered outputs.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= ST_IDLE;
            tgt_level_q <= '0;
            dur_q       <= '0;
            phase_q     <= '0;
            level_q     <= '0;
            en_q        <= 1'b0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_level_q <= tgt_level_d;
            dur_q       <= dur_d;
            phase_q     <= phase_d;
            level_q     <= level_d;
            en_q        <= en_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pwm_en    = en_q;
    assign pwm_dir   = dir_q;
    assign pwm_level = level_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_motor_seq_ctrl.sv
// Testbench for motor_seq_ctrl with TICK_DIV=4, RAMP_TICKS=2, DEAD_TICKS=3.
// Expected per-cycle traces come from a move-level model built from the
// phase lengths (coast, ramp levels, run, ramp down, done).
module tb_motor_seq_ctrl;

    localparam int TD   = 4;
    localparam int RAMP = 2;
    localparam int DEAD = 3;

    logic        sclk;
    logic        s_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [2:0]  cmd_level;
    logic [15:0] cmd_dur;
    logic        estop;
    logic        pwm_en;
    logic        pwm_dir;
    logic [2:0]  pwm_level;
    logic        busy;
    logic        done;

    motor_seq_ctrl #(
        .TICK_DIV   (TD),
        .RAMP_TICKS (RAMP),
        .DEAD_TICKS (DEAD)
    ) dut (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_level (cmd_level),
        .cmd_dur   (cmd_dur),
        .estop     (estop),
        .pwm_en    (pwm_en),
        .pwm_dir   (pwm_dir),
        .pwm_level (pwm_level),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observed vector layout: {cmd_ready, pwm_en, pwm_dir, pwm_level[2:0], busy, done}
    logic [7:0] exp_q[$];
    bit         model_dir;

    typedef struct {
        bit dir;
        int lvl;
        int dur;
        int exp_busy;
        int exp_dead;
        int exp_peak;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [7:0] obs();
        return {cmd_ready, pwm_en, pwm_dir, pwm_level, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int n, input bit en, input bit d, input int lvl);
        logic [2:0] l;
        l = lvl[2:0];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({1'b0, en, d, l, 1'b1, 1'b0});
        end
    endtask

    // Expected trace of one move, from the cycle after accept to the done cycle.
    task automatic build(input bit d, input int lvl, input int dur);
        int first_down;
        exp_q.delete();
        if (d != model_dir) push(DEAD * TD, 1'b0, d, 0);
        model_dir = d;
        if (lvl == 0) push(1, 1'b1, d, 0);
        else for (int l = 0; l < lvl; l++) push(RAMP * TD, 1'b1, d, l);
        push((dur == 0) ? 1 : dur * TD, 1'b1, d, lvl);
        first_down = (lvl == 0) ? 0 : lvl - 1;
        for (int l = first_down; l >= 0; l--) push(RAMP * TD, 1'b1, d, l);
        exp_q.push_back({1'b1, 1'b0, d, 3'd0, 1'b0, 1'b1});
    endtask

    // Called at a negedge in IDLE: present the command for one edge.
    task automatic issue(input bit d, input int lvl, input int dur);
        check("ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_level = lvl[2:0];
        cmd_dur   = dur[15:0];
        build(d, lvl, dur);
        @(negedge sclk);
        cmd_valid = 1'b0;
    endtask

    // Compare the DUT against the expected trace, optionally poking cmd_valid while busy.
    task automatic follow(input int poke_at, output int busy_cnt, output int dead_cnt, output int peak);
        busy_cnt = 0;
        dead_cnt = 0;
        peak     = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("trace[%0d]", i), obs(), exp_q[i]);
            if (busy) busy_cnt++;
            if (busy && !pwm_en) dead_cnt++;
            if (int'(pwm_level) > peak) peak = int'(pwm_level);
            if (i == poke_at) begin
                cmd_valid = 1'b1;
                cmd_dir   = ~cmd_dir;
                cmd_level = 3'd7;
                cmd_dur   = 16'd1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge sclk);
        end
        check("done_one_cycle", {busy, done}, 2'b00);
    endtask

    initial begin
        int bc, dc, pk;
        int d, lvl, dur, poke;

        vecs[0] = '{0, 3, 5, 68, 0, 3};
        vecs[1] = '{1, 1, 2, 36, 12, 1};
        vecs[2] = '{1, 0, 0, 10, 0, 0};
        vecs[3] = '{0, 7, 1, 128, 12, 7};
        vecs[4] = '{0, 2, 0, 33, 0, 2};

        s_rst_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_level = 3'd0;
        cmd_dur   = 16'd0;
        estop     = 1'b0;
        model_dir = 1'b0;

        repeat (3) @(negedge sclk);
        check("reset_outputs", obs(), 8'b1000_0000);
        s_rst_n = 1'b1;
        @(negedge sclk);
        check("after_reset_release", obs(), 8'b1000_0000);

        // Table-driven moves
        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].dir, vecs[v].lvl, vecs[v].dur);
            follow(-1, bc, dc, pk);
            check($sformatf("vec%0d_busy_cycles", v), bc, vecs[v].exp_busy);
            check($sformatf("vec%0d_dead_cycles", v), dc, vecs[v].exp_dead);
            check($sformatf("vec%0d_peak_level", v), pk, vecs[v].exp_peak);
        end

        // cmd_valid while busy is ignored
        issue(1, 4, 1);
        follow(3, bc, dc, pk);
        check("poke_busy_cycles", bc, 12 + 32 + 4 + 32);

        // estop during RUN at level 3, with cmd_valid held
        issue(1, 3, 5);
        repeat (30) @(negedge sclk);
        check("pre_estop_level", {pwm_en, pwm_level}, 4'b1011);
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_level = 3'd5;
        cmd_dur   = 16'd3;
        @(negedge sclk);
        check("estop_outputs", obs(), 8'b0010_0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge sclk);
            check("estop_hold_no_accept", {cmd_ready, busy, done}, 3'b000);
        end
        estop = 1'b0;
        #1;
        check("ready_after_estop", cmd_ready, 1);
        build(0, 5, 3);
        @(negedge sclk);
        cmd_valid = 1'b0;
        follow(-1, bc, dc, pk);

        // estop and cmd_valid arriving together in IDLE
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        @(negedge sclk);
        check("estop_with_valid", {busy, pwm_en, pwm_dir}, 3'b000);
        estop     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge sclk);
        check("idle_after_estop_pulse", obs(), 8'b1000_0000);

        // asynchronous reset mid RAMP_UP
        issue(1, 5, 2);
        repeat (20) @(negedge sclk);
        check("pre_reset_ramp", {pwm_en, pwm_dir, pwm_level, busy}, 6'b11_001_1);
        #2;
        s_rst_n = 1'b0;
        #1;
        check("async_reset_outputs", obs(), 8'b1000_0000);
        @(negedge sclk);
        s_rst_n   = 1'b1;
        model_dir = 1'b0;
        @(negedge sclk);
        issue(0, 2, 1);
        follow(-1, bc, dc, pk);
        check("post_reset_busy_cycles", bc, 16 + 4 + 16);

        // Randomized moves against the model
        for (int r = 0; r < 12; r++) begin
            d    = int'($urandom_range(0, 1));
            lvl  = int'($urandom_range(0, 7));
            dur  = int'($urandom_range(0, 5));
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            issue(d[0], lvl, dur);
            follow(poke, bc, dc, pk);
            check($sformatf("rand%0d_peak", r), pk, lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
